// File: rtl/core_exc_ctrl_pkg.sv
// Shared core definitions: SR layout, modes, exception FSM states and save-stack frame.
package core_exc_ctrl_pkg;

   typedef logic [1:0] mode_t;
   localparam mode_t MODE_USR = 2'd0;
   localparam mode_t MODE_SUP = 2'd1;
   localparam mode_t MODE_EXC = 2'd2;
   localparam mode_t MODE_IRQ = 2'd3;

   typedef struct packed {
      logic [3:0] flags;
      mode_t      mode;
      logic       i;
   } sr_t;

   typedef logic [3:0] cause_t;

   typedef enum logic [1:0] {
      IDLE,
      FLUSH,
      ENTER,
      RESTORE
   } exc_state_t;

   localparam int unsigned CORE_PC_W = 32;

   typedef struct packed {
      sr_t                  sr;
      logic [CORE_PC_W-1:0] pc;
   } exc_frame_t;

   // Interrupt causes occupy codes 8..15, above the synchronous exception causes.
   function automatic cause_t irq_cause(input logic [2:0] idx);
      return {1'b1, idx};
   endfunction

endpackage

// File: rtl/core_exc_ctrl_stack.sv
// Small LIFO holding saved {SR, PC} frames for nested exception entry.
module core_exc_stack
   import core_exc_ctrl_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   parameter type         T     = exc_frame_t
) (
   input  logic clk,
   input  logic rst,
   input  logic push_i,
   input  logic pop_i,
   input  T     data_i,
   output T     top_o,
   output logic full_o,
   output logic empty_o
);

   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [CW-1:0] cnt_q, cnt_d;
   T              mem_q [DEPTH];

   assign full_o  = (cnt_q == CW'(DEPTH));
   assign empty_o = (cnt_q == '0);

   always_comb begin
      cnt_d = cnt_q;
      if (push_i && !full_o)
         cnt_d = cnt_q + 1'b1;
      else if (pop_i && !empty_o)
         cnt_d = cnt_q - 1'b1;
   end

   always_comb begin
      top_o = '0;
      if (!empty_o)
         top_o = mem_q[AW'(cnt_q - 1'b1)];
   end

   always_ff @(posedge clk) begin
      if (!rst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   always_ff @(posedge clk) begin
      if (push_i && !full_o)
         mem_q[AW'(cnt_q)] <= data_i;
   end

endmodule

// File: rtl/core_exc_ctrl.sv
// Exception/interrupt sequencer: arbitrates entry and return, saves/restores SR and PC,
// and drives the SR block's write_sr/write_mode/write_i port group.
module core_exc_ctrl
   import core_exc_ctrl_pkg::*;
#(
   parameter int unsigned     PC_W     = 32,
   parameter int unsigned     NIRQ     = 8,
   parameter int unsigned     DEPTH    = 2,
   parameter logic [PC_W-1:0] VEC_BASE = PC_W'(32'h0000_0100)
) (
   input  logic            clk,
   input  logic            rst,
   input  sr_t             sr,
   input  logic [NIRQ-1:0] irq,
   input  logic            exc_req,
   input  logic [2:0]      exc_cause,
   input  logic [PC_W-1:0] exc_pc,
   input  logic [PC_W-1:0] irq_pc,
   input  logic            reti,
   input  logic            drain_done,
   output logic            write_sr,
   output sr_t             sr_out,
   output logic            write_mode,
   output mode_t           mode,
   output logic            write_i,
   output logic            i,
   output logic            flush,
   output logic            redirect,
   output logic [PC_W-1:0] redirect_pc,
   output logic            exc_ack,
   output logic [NIRQ-1:0] irq_ack,
   output cause_t          cause,
   output logic            fault
);

   typedef struct packed {
      sr_t             sr;
      logic [PC_W-1:0] pc;
   } frame_t;

   exc_state_t      state_q, state_d;
   logic            is_exc_q, is_exc_d;
   logic [2:0]      idx_q, idx_d;
   cause_t          lcause_q, lcause_d;
   logic [PC_W-1:0] lpc_q, lpc_d;
   cause_t          cause_q, cause_d;
   logic            fault_q, fault_d;

   logic            st_push, st_pop, st_full, st_empty;
   frame_t          st_top, st_in;
   logic            irq_any;
   logic [2:0]      irq_idx;
   logic [PC_W-1:0] vec_pc;

   assign irq_any = sr.i && (|irq);
   assign st_in   = '{sr: sr, pc: lpc_q};
   assign vec_pc  = VEC_BASE + PC_W'({lcause_q, 2'b00});
   assign cause   = cause_q;
   assign fault   = fault_q;

   // Scan downward so the lowest-index set line is the one left standing.
   always_comb begin
      irq_idx = '0;
      for (int unsigned k = NIRQ; k > 0; k--)
         if (irq[k-1]) irq_idx = 3'(k - 1);
   end

   core_exc_stack #(
      .DEPTH (DEPTH),
      .T     (frame_t)
   ) u_stack (
      .clk     (clk),
      .rst     (rst),
      .push_i  (st_push),
      .pop_i   (st_pop),
      .data_i  (st_in),
      .top_o   (st_top),
      .full_o  (st_full),
      .empty_o (st_empty)
   );

   always_comb begin
      state_d     = state_q;
      is_exc_d    = is_exc_q;
      idx_d       = idx_q;
      lcause_d    = lcause_q;
      lpc_d       = lpc_q;
      cause_d     = cause_q;
      fault_d     = fault_q;
      st_push     = 1'b0;
      st_pop      = 1'b0;
      write_sr    = 1'b0;
      sr_out      = '0;
      write_mode  = 1'b0;
      mode        = '0;
      write_i     = 1'b0;
      i           = 1'b0;
      flush       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = '0;
      exc_ack     = 1'b0;
      irq_ack     = '0;
      case (state_q)
         IDLE: begin
            if (exc_req) begin
               is_exc_d = 1'b1;
               lcause_d = {1'b0, exc_cause};
               lpc_d    = exc_pc;
               state_d  = FLUSH;
            end else if (reti) begin
               state_d  = RESTORE;
            end else if (irq_any) begin
               is_exc_d = 1'b0;
               idx_d    = irq_idx;
               lcause_d = irq_cause(irq_idx);
               lpc_d    = irq_pc;
               state_d  = FLUSH;
            end
         end
         FLUSH: begin
            flush = 1'b1;
            if (drain_done) state_d = ENTER;
         end
         ENTER: begin
            if (st_full) begin
               fault_d = 1'b1;
            end else begin
               st_push     = 1'b1;
               write_mode  = 1'b1;
               mode        = is_exc_q ? MODE_EXC : MODE_IRQ;
               write_i     = 1'b1;
               i           = 1'b0;
               redirect    = 1'b1;
               redirect_pc = vec_pc;
            end
            if (is_exc_q) exc_ack = 1'b1;
            else          irq_ack = NIRQ'(1) << idx_q;
            cause_d = lcause_q;
            state_d = IDLE;
         end
         RESTORE: begin
            flush = 1'b1;
            if (st_empty) begin
               fault_d = 1'b1;
            end else begin
               write_sr    = 1'b1;
               sr_out      = st_top.sr;
               redirect    = 1'b1;
               redirect_pc = st_top.pc;
               st_pop      = 1'b1;
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= IDLE;
         is_exc_q <= 1'b0;
         idx_q    <= '0;
         lcause_q <= '0;
         lpc_q    <= '0;
         cause_q  <= '0;
         fault_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         is_exc_q <= is_exc_d;
         idx_q    <= idx_d;
         lcause_q <= lcause_d;
         lpc_q    <= lpc_d;
         cause_q  <= cause_d;
         fault_q  <= fault_d;
      end
   end

endmodule

// File: doc/core_exc_ctrl.md
# core_exc_ctrl

Exception/interrupt controller that sequences the core status register (SR). It arbitrates synchronous exceptions, external interrupt lines and return-from-exception requests. On entry it saves SR and the faulting PC on a small hardware stack, then switches mode, clears the interrupt-enable bit and redirects fetch. On return it restores both. It sits beside the SR register-file block and drives that block's `write_sr`/`write_mode`/`write_i` port group.

## Interface
Parameters:
- `PC_W`, 32, program counter width
- `NIRQ`, 8, number of interrupt lines (≤ 8)
- `DEPTH`, 2, save-stack depth (nesting levels)
- `VEC_BASE`, 32'h0000_0100, vector table base

Ports:
- Clock and reset: one clock, `clk`; reset `rst` is synchronous, active-low.
- `clk` in 1 clock
- `rst` in 1 synchronous active-low reset
- `sr` in sr_t current SR (from SR block)
- `irq` in NIRQ level interrupt lines
- `exc_req` in 1 synchronous exception request, held until `exc_ack`
- `exc_cause` in 3 exception cause code
- `exc_pc` in PC_W PC of faulting instruction
- `irq_pc` in PC_W PC to resume at after interrupt
- `reti` in 1 return-from-exception pulse from decode
- `drain_done` in 1 pipeline drained after flush
- `write_sr`, `sr_out` out 1, sr_t full SR write
- `write_mode`, `mode` out 1, mode_t mode write
- `write_i`, `i` out 1, 1 interrupt-enable write
- `flush` out 1 pipeline flush request
- `redirect`, `redirect_pc` out 1, PC_W fetch redirect
- `exc_ack` out 1 exception accepted (pulse)
- `irq_ack` out NIRQ one-hot interrupt accepted (pulse)
- `cause` out 4 cause of most recent entry
- `fault` out 1 sticky stack overflow/underflow

## Operation
- States: IDLE, FLUSH, ENTER, RESTORE.
- IDLE arbitration, priority high→low:
  - `exc_req`
  - `reti`
  - lowest-index set `irq` bit, only when `sr.i`=1
- The winner is latched in IDLE. Requests are not sampled in other states.
- Exception or IRQ wins: go to FLUSH.
  - Latch the cause: `{1'b0,exc_cause}` for an exception, `8+idx` for an interrupt.
  - Latch the PC: `exc_pc` for an exception, `irq_pc` for an interrupt.
- FLUSH: assert `flush`. Stay until `drain_done`=1, then go to ENTER.
- ENTER (one cycle):
  - Push {`sr`, latched PC} onto the stack.
  - Pulse `write_mode` with `mode`=MODE_EXC (exception) or MODE_IRQ (interrupt).
  - Pulse `write_i` with `i`=0.
  - Pulse `redirect` with `redirect_pc` = VEC_BASE + cause×4, truncated to PC_W.
  - Pulse `exc_ack` or `irq_ack[idx]`, update `cause`, return to IDLE.
- `reti` wins: go to RESTORE (one cycle).
  - Assert `flush`.
  - Pulse `write_sr` with `sr_out` = stacked SR.
  - Pulse `redirect` with `redirect_pc` = stacked PC.
  - Pop the stack, return to IDLE.
- Stack full at entry:
  - Set `fault`.
  - ENTER issues no push, no SR writes and no redirect.
  - `exc_ack`/`irq_ack` still pulse.
- Stack empty at `reti`: set `fault`. RESTORE issues no writes and no redirect.
- The SR flag field is never driven here; the SR block keeps ALU flag updates.
- `fault` clears only on reset.

## Timing
- Reset (rst=0 at posedge):
  - state=IDLE, stack empty.
  - All pulse outputs are 0; `flush`, `fault`, `cause`, `redirect_pc`, `sr_out`, `mode`, `i` are 0.
  - Reset mid-FLUSH/ENTER abandons the entry: no ack, no push.
- Request sampled at edge N → `flush` high from N+1.
- `drain_done` seen at edge M → ENTER outputs valid during cycle M+1. The SR block registers them at edge M+2.
- Minimum entry latency: request to redirect in 2 cycles (`drain_done` already high).
- `reti` sampled at edge N → RESTORE outputs during cycle N+1. Next arbitration at edge N+2.
- All write/ack/redirect pulses last exactly one cycle.
- Output `sr_out`/`mode`/`i` are don't-care when their write strobe is 0. They are driven as 0.

## Structure
- Add to the shared core defines package:
  - `exc_state_t` enum (IDLE, FLUSH, ENTER, RESTORE)
  - `cause_t` (4-bit)
  - mode_t constants MODE_EXC and MODE_IRQ
  - a packed `exc_frame_t` {sr_t sr; logic [PC_W-1:0] pc}
- Sub-module `core_exc_stack`: a DEPTH-entry LIFO of exc_frame_t.
  - Inputs: push, pop.
  - Outputs: top, full, empty.
  - Push and pop in the same cycle are never issued.

## Test plan
- irq=8'b0000_0110, sr.i=1, `drain_done` tied 1 → `irq_ack`=8'b0000_0010; `redirect_pc`=0x124; mode=MODE_IRQ, i=0; `cause`=9.
- `exc_req` with cause 3 and irq[0] asserted in the same cycle → exception taken first; `redirect_pc`=0x10C. IRQ is taken only after `reti` restores i=1.
- Entry then `reti` → SR restored bit-exact from the stack; `redirect_pc` = the saved `irq_pc`; stack empty.
- Three nested exceptions with DEPTH=2 → third entry sets `fault`; no redirect; stack depth stays 2.
- `drain_done` held low 5 cycles → `flush` high 5 cycles, no SR writes. Reset asserted mid-FLUSH → all outputs 0, no ack.
- `reti` on an empty stack → `fault`=1; no `write_sr`; no redirect.
